// File: rtl/board_state_keeper_pkg.sv
// board_state_keeper_pkg
//   Shared types and constants for the board state keeper:
//   screen_state_t  - system screen selector (block runs only on CHESS_SCREEN)
//   keeper_state_t  - keeper control states
//   board_t         - 8x8 array of 4-bit piece codes, indexed board[x][y]
//   piece constants and start_position() giving the initial board.
package board_state_keeper_pkg;

   typedef enum logic [1:0] {
      TITLE_SCREEN = 2'd0,
      CHESS_SCREEN = 2'd1,
      END_SCREEN   = 2'd2
   } screen_state_t;

   typedef enum logic [2:0] {
      INIT,
      WAIT,
      APPLY,
      SEND,
      OVER
   } keeper_state_t;

   typedef logic [3:0]             piece_t;
   typedef logic [7:0][7:0][3:0]   board_t;

   localparam piece_t PIECE_EMPTY = 4'd15;
   localparam piece_t P1_KING     = 4'd5;
   localparam piece_t P0_KING     = 4'd11;
   localparam piece_t P1_PAWN     = 4'd0;
   localparam piece_t P0_PAWN     = 4'd6;
   localparam piece_t P1_QUEEN    = 4'd4;
   localparam piece_t P0_QUEEN    = 4'd10;

   // Back ranks, element [x] is file x (x=0 is the rightmost nibble).
   localparam logic [7:0][3:0] BACK_RANK_P0 =
      {4'd9, 4'd7, 4'd8, 4'd11, 4'd10, 4'd8, 4'd7, 4'd9};
   localparam logic [7:0][3:0] BACK_RANK_P1 =
      {4'd3, 4'd1, 4'd2, 4'd5, 4'd4, 4'd2, 4'd1, 4'd3};

   function automatic board_t start_position();
      board_t b;
      b = '1;
      for (int unsigned x = 0; x < 8; x++) begin
         b[x[2:0]][0] = BACK_RANK_P0[x[2:0]];
         b[x[2:0]][1] = P0_PAWN;
         b[x[2:0]][6] = P1_PAWN;
         b[x[2:0]][7] = BACK_RANK_P1[x[2:0]];
      end
      return b;
   endfunction

   // Codes 0-5 belong to player 1, 6-11 to player 0; empty belongs to nobody.
   function automatic logic owned_by(piece_t p, logic who);
      if (who) return (p <= 4'd5);
      else     return (p >= 4'd6) && (p <= 4'd11);
   endfunction

endpackage

// File: rtl/board_state_keeper_if.sv
// board_state_keeper_if
//   Move traffic around the board state keeper:
//   moved/move_packet  - validated local move from move selection
//   rx_valid/rx_packet - move received from the remote player's link
//   tx_valid/tx_packet/tx_ready - local move forwarded to the link transmitter
//   master: the surrounding system; slave: the keeper.
interface board_state_keeper_if;
   logic        moved;
   logic [11:0] move_packet;
   logic        rx_valid;
   logic [11:0] rx_packet;
   logic        tx_ready;
   logic        tx_valid;
   logic [11:0] tx_packet;

   modport master (
      output moved, move_packet, rx_valid, rx_packet, tx_ready,
      input  tx_valid, tx_packet
   );

   modport slave (
      input  moved, move_packet, rx_valid, rx_packet, tx_ready,
      output tx_valid, tx_packet
   );
endinterface

// File: rtl/board_state_keeper.sv
// board_state_keeper
//   Holds the authoritative chess board and side-to-move, commits local and
//   remote moves, forwards local moves to the link and detects king capture.
//   Ports:
//     CLOCK_50     - system clock
//     reset        - synchronous, active-high
//     sys_state    - block advances only on CHESS_SCREEN
//     new_game     - pulse, reload start position (overrides everything)
//     player       - identity of this board's player
//     link         - board_state_keeper_if.slave (moves in, tx handshake out)
//     stable_board - board[x][y], 15 = empty
//     curr_player  - side to move
//     game_over    - set once a king is captured; winner is the capturer
//     proto_err    - sticky, rejected or out-of-turn move seen
//     move_count   - committed moves, saturating
//   Build option: AUTO_PROMOTE_EN promotes pawns reaching the last rank to queens.
module board_state_keeper
   import board_state_keeper_pkg::*;
#(
   parameter logic        FIRST_PLAYER = 1'b0,
   parameter int unsigned MOVE_CNT_W   = 8
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  screen_state_t         sys_state,
   input  logic                  new_game,
   input  logic                  player,
   board_state_keeper_if.slave   link,
   output board_t                stable_board,
   output logic                  curr_player,
   output logic                  game_over,
   output logic                  winner,
   output logic                  proto_err,
   output logic [MOVE_CNT_W-1:0] move_count
);

   keeper_state_t         state_q, state_d;
   board_t                board_q, board_d;
   logic                  curr_player_q, curr_player_d;
   logic                  game_over_q, game_over_d;
   logic                  winner_q, winner_d;
   logic                  proto_err_q, proto_err_d;
   logic [MOVE_CNT_W-1:0] move_count_q, move_count_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [11:0]           tx_packet_q, tx_packet_d;
   logic [11:0]           pkt_q, pkt_d;
   logic                  from_local_q, from_local_d;

   logic [2:0] src_x, src_y, dst_x, dst_y;
   piece_t     src_piece, dst_piece, placed;
   logic       takes_king;

   assign src_x = pkt_q[11:9];
   assign src_y = pkt_q[8:6];
   assign dst_x = pkt_q[5:3];
   assign dst_y = pkt_q[2:0];

   assign src_piece  = board_q[src_x][src_y];
   assign dst_piece  = board_q[dst_x][dst_y];
   assign takes_king = (dst_piece == P1_KING) || (dst_piece == P0_KING);

   always_comb begin
      placed = src_piece;
`ifdef AUTO_PROMOTE_EN
      if (src_piece == P0_PAWN && dst_y == 3'd7)
         placed = P0_QUEEN;
      else if (src_piece == P1_PAWN && dst_y == 3'd0)
         placed = P1_QUEEN;
`endif
   end

   always_comb begin
      state_d       = state_q;
      board_d       = board_q;
      curr_player_d = curr_player_q;
      game_over_d   = game_over_q;
      winner_d      = winner_q;
      proto_err_d   = proto_err_q;
      move_count_d  = move_count_q;
      tx_valid_d    = tx_valid_q;
      tx_packet_d   = tx_packet_q;
      pkt_d         = pkt_q;
      from_local_d  = from_local_q;

      if (new_game) begin
         state_d    = INIT;
         tx_valid_d = 1'b0;
      end else if (sys_state == CHESS_SCREEN) begin
         unique case (state_q)
            INIT: begin
               board_d       = start_position();
               curr_player_d = FIRST_PLAYER;
               game_over_d   = 1'b0;
               winner_d      = 1'b0;
               proto_err_d   = 1'b0;
               move_count_d  = '0;
               tx_valid_d    = 1'b0;
               state_d       = WAIT;
            end

            WAIT: begin
               // At most one of the two sources can match the turn, so the
               // other (if present) is always the protocol error.
               if (link.moved && (curr_player_q == player)) begin
                  pkt_d        = link.move_packet;
                  from_local_d = 1'b1;
                  state_d      = APPLY;
               end else if (link.rx_valid && (curr_player_q != player)) begin
                  pkt_d        = link.rx_packet;
                  from_local_d = 1'b0;
                  state_d      = APPLY;
               end
               if ((link.moved && (curr_player_q != player)) ||
                   (link.rx_valid && (curr_player_q == player)))
                  proto_err_d = 1'b1;
            end

            APPLY: begin
               // owned_by() is false for an empty square, covering that case.
               if ((pkt_q[11:6] == pkt_q[5:0]) || !owned_by(src_piece, curr_player_q)) begin
                  proto_err_d = 1'b1;
                  state_d     = WAIT;
               end else begin
                  board_d[dst_x][dst_y] = placed;
                  board_d[src_x][src_y] = PIECE_EMPTY;
                  curr_player_d         = ~curr_player_q;
                  if (move_count_q != '1)
                     move_count_d = move_count_q + 1'b1;
                  if (takes_king) begin
                     game_over_d = 1'b1;
                     winner_d    = curr_player_q;
                  end
                  if (from_local_q) begin
                     tx_valid_d  = 1'b1;
                     tx_packet_d = pkt_q;
                     state_d     = SEND;
                  end else if (takes_king || game_over_q) begin
                     state_d = OVER;
                  end else begin
                     state_d = WAIT;
                  end
               end
            end

            SEND: begin
               if (link.tx_ready) begin
                  tx_valid_d = 1'b0;
                  state_d    = game_over_q ? OVER : WAIT;
               end
               if (link.moved || link.rx_valid)
                  proto_err_d = 1'b1;
            end

            OVER: begin
               tx_valid_d = 1'b0;
            end

            default: state_d = INIT;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q       <= INIT;
         board_q       <= '1;
         curr_player_q <= FIRST_PLAYER;
         game_over_q   <= 1'b0;
         winner_q      <= 1'b0;
         proto_err_q   <= 1'b0;
         move_count_q  <= '0;
         tx_valid_q    <= 1'b0;
         tx_packet_q   <= '0;
         pkt_q         <= '0;
         from_local_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         board_q       <= board_d;
         curr_player_q <= curr_player_d;
         game_over_q   <= game_over_d;
         winner_q      <= winner_d;
         proto_err_q   <= proto_err_d;
         move_count_q  <= move_count_d;
         tx_valid_q    <= tx_valid_d;
         tx_packet_q   <= tx_packet_d;
         pkt_q         <= pkt_d;
         from_local_q  <= from_local_d;
      end
   end

   assign stable_board   = board_q;
   assign curr_player    = curr_player_q;
   assign game_over      = game_over_q;
   assign winner         = winner_q;
   assign proto_err      = proto_err_q;
   assign move_count     = move_count_q;
   assign link.tx_valid  = tx_valid_q;
   assign link.tx_packet = tx_packet_q;

endmodule

// File: tb/tb_board_state_keeper.sv
// tb_board_state_keeper
//   Scoreboarded bench: the stimulus process updates a reference model of the
//   game and queues expected snapshots (due on a given cycle) and expected
//   transmitted packets; a monitor compares them against the DUT.
module tb_board_state_keeper;
   import board_state_keeper_pkg::*;

   logic          clk = 1'b0;
   logic          reset;
   screen_state_t sys_state;
   logic          new_game;
   logic          player;
   board_t        stable_board;
   logic          curr_player, game_over, winner, proto_err;
   logic [7:0]    move_count;

   board_state_keeper_if bus();

   board_state_keeper #(.FIRST_PLAYER(1'b0), .MOVE_CNT_W(8)) dut (
      .CLOCK_50     (clk),
      .reset        (reset),
      .sys_state    (sys_state),
      .new_game     (new_game),
      .player       (player),
      .link         (bus),
      .stable_board (stable_board),
      .curr_player  (curr_player),
      .game_over    (game_over),
      .winner       (winner),
      .proto_err    (proto_err),
      .move_count   (move_count)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   int   mb [8][8];
   logic m_turn, m_over, m_win, m_perr, m_player;
   int   m_mc;
   int   txn = 0;

   function automatic logic owner_ok(input int p, input logic side);
      if (side) return (p >= 0 && p <= 5);
      return (p >= 6 && p <= 11);
   endfunction

   function automatic void model_start();
      int r0 [8] = '{9, 7, 8, 10, 11, 8, 7, 9};
      int r7 [8] = '{3, 1, 2, 4, 5, 2, 1, 3};
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 8; y++)
            mb[x][y] = (y == 0) ? r0[x] : (y == 1) ? 6 : (y == 6) ? 0 : (y == 7) ? r7[x] : 15;
      m_turn = 1'b0; m_over = 1'b0; m_win = 1'b0; m_perr = 1'b0; m_mc = 0;
   endfunction

   function automatic board_t model_board();
      board_t b;
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 8; y++)
            b[x][y] = 4'(mb[x][y]);
      return b;
   endfunction

   // Returns 1 when the move is committed.
   function automatic logic model_apply(input logic [11:0] pk);
      int sx = int'(pk[11:9]);
      int sy = int'(pk[8:6]);
      int dx = int'(pk[5:3]);
      int dy = int'(pk[2:0]);
      int p  = mb[sx][sy];
      int d  = mb[dx][dy];
      int np = p;
      if ((sx == dx && sy == dy) || !owner_ok(p, m_turn)) begin
         m_perr = 1'b1;
         return 1'b0;
      end
`ifdef AUTO_PROMOTE_EN
      if (p == 6 && dy == 7) np = 10;
      else if (p == 0 && dy == 0) np = 4;
`endif
      mb[dx][dy] = np;
      mb[sx][sy] = 15;
      if (d == 5 || d == 11) begin
         m_over = 1'b1;
         m_win  = m_turn;
      end
      m_turn = ~m_turn;
      if (m_mc < 255) m_mc++;
      return 1'b1;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      int unsigned due;
      int          id;
      board_t      board;
      logic        cp, go, win, perr, txv;
      int          mc;
   } exp_t;

   exp_t        exp_q [$];
   logic [11:0] tx_q  [$];
   int          vectors = 0;
   int          miscompares = 0;

   function automatic void push_exp(input int unsigned due, input logic txv);
      exp_t e;
      e.due = due; e.id = txn; e.board = model_board();
      e.cp = m_turn; e.go = m_over; e.win = m_win; e.perr = m_perr; e.txv = txv;
      e.mc = m_mc;
      exp_q.push_back(e);
   endfunction

   task automatic cmp(input string name, input int id, input logic [255:0] act, input logic [255:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s txn=%0d cyc=%0d got=%0h expected=%0h", name, id, cyc, act, want);
      end
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (bus.tx_valid && bus.tx_ready) begin
         if (tx_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL tx_unexpected cyc=%0d got=%0h expected=none", cyc, bus.tx_packet);
         end else begin
            cmp("tx_packet", txn, 256'(bus.tx_packet), 256'(tx_q.pop_front()));
         end
      end
      while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
         mon_e = exp_q.pop_front();
         if (mon_e.due < cyc) begin
            vectors++; miscompares++;
            $display("FAIL stale txn=%0d got=cyc%0d expected=cyc%0d", mon_e.id, cyc, mon_e.due);
         end else begin
            cmp("board",       mon_e.id, 256'(stable_board), 256'(mon_e.board));
            cmp("curr_player", mon_e.id, 256'(curr_player),  256'(mon_e.cp));
            cmp("game_over",   mon_e.id, 256'(game_over),    256'(mon_e.go));
            cmp("winner",      mon_e.id, 256'(winner),       256'(mon_e.win));
            cmp("proto_err",   mon_e.id, 256'(proto_err),    256'(mon_e.perr));
            cmp("move_count",  mon_e.id, 256'(move_count),   256'(mon_e.mc));
            cmp("tx_valid",    mon_e.id, 256'(bus.tx_valid), 256'(mon_e.txv));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One pulse in WAIT (or OVER); for a committed local move, run the SEND
   // phase with `hold` cycles of tx_ready low and an optional stray pulse.
   task automatic issue(input logic mv, input logic rv, input logic [11:0] mp,
                        input logic [11:0] rp, input logic gated,
                        input int unsigned hold, input logic stray);
      int unsigned k = cyc;
      logic        taken = 1'b0, is_local = 1'b0, ok;
      logic [11:0] pk = '0;
      int unsigned when;
      txn++;
      sys_state = gated ? TITLE_SCREEN : CHESS_SCREEN;
      bus.moved = mv; bus.move_packet = mp;
      bus.rx_valid = rv; bus.rx_packet = rp;
      tick();
      bus.moved = 1'b0; bus.rx_valid = 1'b0; sys_state = CHESS_SCREEN;
      if (!gated && !m_over) begin
         if (mv && m_turn == m_player) begin taken = 1'b1; is_local = 1'b1; pk = mp; end
         else if (rv && m_turn != m_player) begin taken = 1'b1; pk = rp; end
         if ((mv && m_turn != m_player) || (rv && m_turn == m_player)) m_perr = 1'b1;
      end
      if (!taken) begin
         push_exp(k + 2, 1'b0);
         tick();
         return;
      end
      ok = model_apply(pk);
      tick();
      if (!ok || !is_local) begin
         push_exp(k + 2, 1'b0);
         return;
      end
      push_exp(k + 2, 1'b1);
      tx_q.push_back(pk);
      when = $urandom_range(0, hold);
      for (int unsigned i = 0; i <= hold; i++) begin
         bus.tx_ready = (i == hold);
         if (stray && i == when) begin
            if ($urandom_range(0, 1) == 1) bus.moved = 1'b1; else bus.rx_valid = 1'b1;
            m_perr = 1'b1;
         end
         tick();
         bus.moved = 1'b0; bus.rx_valid = 1'b0;
      end
      bus.tx_ready = 1'b0;
      push_exp(k + 3 + hold, 1'b0);
   endtask

   task automatic do_new_game(input logic newp, input logic noise);
      int unsigned k = cyc;
      txn++;
      new_game = 1'b1;
      bus.moved = noise; bus.rx_valid = noise;
      bus.move_packet = 12'h863; bus.rx_packet = 12'h9A4;
      tick();
      new_game = 1'b0; bus.moved = 1'b0; bus.rx_valid = 1'b0;
      player = newp; m_player = newp;
      model_start();
      push_exp(k + 2, 1'b0);
      tick();
   endtask

   function automatic logic [11:0] rand_pkt(input logic side);
      int unsigned sx = $urandom_range(0, 7), sy = $urandom_range(0, 7);
      int unsigned dx = $urandom_range(0, 7), dy = $urandom_range(0, 7);
      for (int t = 0; t < 12 && !owner_ok(mb[sx][sy], side); t++) begin
         sx = $urandom_range(0, 7);
         sy = $urandom_range(0, 7);
      end
      if ($urandom_range(0, 9) == 0) begin dx = sx; dy = sy; end
      return {sx[2:0], sy[2:0], dx[2:0], dy[2:0]};
   endfunction

   initial begin
      logic mv, rv;
      int unsigned k;
      reset = 1'b1; sys_state = CHESS_SCREEN; new_game = 1'b0; player = 1'b0;
      bus.moved = 1'b0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
      bus.move_packet = '0; bus.rx_packet = '0;
      m_player = 1'b0;
      tick(); tick();
      // reset values: empty board, FIRST_PLAYER to move, everything else 0
      for (int x = 0; x < 8; x++) for (int y = 0; y < 8; y++) mb[x][y] = 15;
      m_turn = 1'b0; m_over = 1'b0; m_win = 1'b0; m_perr = 1'b0; m_mc = 0;
      push_exp(cyc, 1'b0);
      reset = 1'b0;
      model_start();
      push_exp(cyc + 1, 1'b0);
      tick();

      // directed game
      issue(1'b1, 1'b0, 12'h863, '0, 1'b0, 3, 1'b0);      // e2e4 style pawn push {4,1,4,3}
      issue(1'b0, 1'b1, '0, 12'h9A4, 1'b0, 0, 1'b0);      // remote {4,6,4,4}
      issue(1'b0, 1'b1, '0, 12'h38D, 1'b0, 0, 1'b0);      // remote out of turn
      issue(1'b1, 1'b0, 12'h863, '0, 1'b1, 0, 1'b0);      // gated pulse is lost
      issue(1'b1, 1'b0, 12'h492, '0, 1'b0, 0, 1'b0);      // src==dst reject
      issue(1'b1, 1'b0, 12'h0D2, '0, 1'b0, 0, 1'b0);      // empty source reject
      issue(1'b1, 1'b0, 12'h627, '0, 1'b0, 1, 1'b0);      // queen takes king
      issue(1'b1, 1'b0, 12'h046, '0, 1'b0, 0, 1'b0);      // ignored in OVER
      issue(1'b0, 1'b1, '0, 12'h38D, 1'b0, 0, 1'b0);      // ignored in OVER
      do_new_game(1'b0, 1'b1);
      issue(1'b1, 1'b0, 12'h046, '0, 1'b0, 0, 1'b0);      // pawn {0,1}->{0,6}
      issue(1'b0, 1'b1, '0, 12'h38D, 1'b0, 0, 1'b0);      // remote {1,6}->{1,5}
      issue(1'b1, 1'b0, 12'h1B7, '0, 1'b0, 2, 1'b1);      // pawn reaches rank 7
      issue(1'b0, 1'b1, '0, 12'h808, 1'b0, 0, 1'b0);      // remote moves a player-0 piece

      // randomized play
      for (int i = 0; i < 220; i++) begin
         if (m_over || $urandom_range(0, 39) == 0) begin
            do_new_game(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            continue;
         end
         k  = $urandom_range(0, 9);
         mv = (k < 5) || (k == 9);
         rv = (k >= 5);
         issue(mv, rv, rand_pkt(m_turn), rand_pkt(m_turn),
               $urandom_range(0, 9) == 0, $urandom_range(0, 3),
               $urandom_range(0, 3) == 0);
      end

      repeat (4) tick();
      while (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         vectors++; miscompares++;
         $display("FAIL unchecked txn=%0d got=none expected=check at cyc%0d", mon_e.id, mon_e.due);
      end
      while (tx_q.size() != 0) begin
         vectors++; miscompares++;
         $display("FAIL tx_missing got=none expected=%0h", tx_q.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
